// File: rtl/pixel_stream_proc_if.sv
// RX/TX FIFO handshake bundle between the pixel processor and the uart FIFOs.
// master = processor side, slave = FIFO side.
interface pixel_stream_proc_if #(
  parameter int DATA_W = 8
);
  logic              rx_empty;
  logic [DATA_W-1:0] r_data;
  logic              rd_uart;
  logic              tx_full;
  logic [DATA_W-1:0] w_data;
  logic              wr_uart;

  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, w_data, wr_uart
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, w_data, wr_uart
  );
endinterface

// File: rtl/pixel_stream_proc.sv
// Byte-stream point-operation pixel processor: pops RX FIFO, applies PASS/ADD/INV/THR,
// pushes the result to the TX FIFO; free-running or one pixel per step tick.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a pixel (and a pending step in step mode); pops it
// ST_PROC  | applies the selected point operation to the captured pixel
// ST_WRITE | offers the result to the TX FIFO until it is accepted
module pixel_stream_proc #(
  parameter int DATA_W   = 8,
  parameter int OFFSET   = 50,
  parameter int THRESH   = 128,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 step_mode,
  input  logic                 step_tick,
  pixel_stream_proc_if.master  bus,
  output logic [DATA_W-1:0]    last_in,
  output logic [CNT_W-1:0]     byte_count,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROC  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [DATA_W:0]  OFFSET_X = (DATA_W+1)'(OFFSET);
  localparam logic [DATA_W:0]  THRESH_X = (DATA_W+1)'(THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] last_in_q, last_in_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step_pending_q, step_pending_d;

  logic              go;
  logic              pop;
  logic              push;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] op_result;

  always_comb begin
    sum       = {1'b0, in_q} + OFFSET_X;
    op_result = in_q;
    case (mode)
      2'b00: op_result = in_q;
      2'b01: begin
        if (SATURATE && sum[DATA_W]) op_result = '1;
        else                         op_result = sum[DATA_W-1:0];
      end
      2'b10: op_result = ~in_q;
      2'b11: op_result = ({1'b0, in_q} >= THRESH_X) ? '1 : '0;
      default: op_result = in_q;
    endcase
  end

  // reset gates go so no pop is issued to the FIFO while held in reset
  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    out_d     = out_q;
    last_in_d = last_in_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    push      = 1'b0;
    go        = reset && !bus.rx_empty && (!step_mode || step_pending_q);

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          pop       = 1'b1;
          in_d      = bus.r_data;
          last_in_d = bus.r_data;
          state_d   = ST_PROC;
        end
      end
      ST_PROC: begin
        out_d   = op_result;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (!bus.tx_full) begin
          push    = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // a tick landing on the consuming pop survives as the next pending step
    step_pending_d = (step_pending_q && !(pop && step_mode)) || step_tick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      in_q           <= '0;
      out_q          <= '0;
      last_in_q      <= '0;
      cnt_q          <= '0;
      step_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_q           <= in_d;
      out_q          <= out_d;
      last_in_q      <= last_in_d;
      cnt_q          <= cnt_d;
      step_pending_q <= step_pending_d;
    end
  end

  assign bus.rd_uart = pop;
  assign bus.wr_uart = push;
  assign bus.w_data  = out_q;
  assign last_in     = last_in_q;
  assign byte_count  = cnt_q;
  assign busy        = (state_q != ST_IDLE);

  a_no_rd_wr_overlap: assert property (@(posedge clk) disable iff (!reset)
    !(bus.rd_uart && bus.wr_uart));

endmodule
